// File: rtl/csr_arbiter.sv
// Shares the execute-stage CSR file port between the core pipeline (priority) and a host/debug port.
// Optional stall performance counter enabled by defining CSR_ARB_PERF_EN.
module csr_arbiter #(
    parameter int DWIDTH   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_csr_we,
    input  logic              core_csr_rd,
    input  logic [11:0]       core_csr_addr,
    input  logic [2:0]        core_csr_func,
    input  logic [DWIDTH-1:0] core_csr_wdata,
    output logic [DWIDTH-1:0] core_csr_rdata,
    output logic              core_stall,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic              host_req_we,
    input  logic [11:0]       host_req_addr,
    input  logic [DWIDTH-1:0] host_req_wdata,
    output logic              host_rsp_valid,
    output logic [DWIDTH-1:0] host_rsp_data,
    input  logic              host_rsp_ready,
    output logic              csr_we,
    output logic              csr_rd,
    output logic [11:0]       csr_addr,
    output logic [2:0]        csr_func,
    output logic [DWIDTH-1:0] csr_data_in,
    input  logic [DWIDTH-1:0] csr_data_out
`ifdef CSR_ARB_PERF_EN
    ,
    output logic [31:0]       arb_stall_cnt
`endif
);

    localparam logic [2:0] FNC_CSRRW = 3'b001;

    typedef enum logic {
        IDLE,
        RSP
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       core_act;
    logic       wait_full;
    logic       host_win;

    assign core_act  = core_csr_we | core_csr_rd;
    assign wait_full = (wait_cnt == 8'(MAX_WAIT));
    assign host_win  = (state == IDLE) & host_req_valid & (~core_act | wait_full);

    // Host accesses use CSRRW so that the old value comes back on reads and writes alike.
    always_comb begin
        host_req_ready = host_win;
        core_stall     = host_win & core_act;
        core_csr_rdata = csr_data_out;
        csr_we         = 1'b0;
        csr_rd         = 1'b0;
        csr_addr       = '0;
        csr_func       = '0;
        csr_data_in    = '0;
        if (host_win) begin
            core_csr_rdata = '0;
            csr_we         = host_req_we;
            csr_rd         = 1'b1;
            csr_addr       = host_req_addr;
            csr_func       = FNC_CSRRW;
            csr_data_in    = host_req_wdata;
        end else if (core_act) begin
            csr_we         = core_csr_we;
            csr_rd         = core_csr_rd;
            csr_addr       = core_csr_addr;
            csr_func       = core_csr_func;
            csr_data_in    = core_csr_wdata;
        end
    end

    // The starvation counter only runs while a host request is blocked by the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            host_rsp_valid <= 1'b0;
            host_rsp_data  <= '0;
            wait_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (host_win) begin
                        state          <= RSP;
                        host_rsp_valid <= 1'b1;
                        host_rsp_data  <= csr_data_out;
                        wait_cnt       <= '0;
                    end else if (!host_req_valid) begin
                        wait_cnt <= '0;
                    end else if (!wait_full) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RSP: begin
                    if (host_rsp_ready) begin
                        state          <= IDLE;
                        host_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    host_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef CSR_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_stall_cnt <= '0;
        end else if (core_stall && (arb_stall_cnt != 32'hFFFF_FFFF)) begin
            arb_stall_cnt <= arb_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_csr_arbiter.sv
// Directed self-checking bench for csr_arbiter: core pass-through, host access, contention,
// backpressure and asynchronous reset during a pending response.
module tb_csr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_csr_we, core_csr_rd;
    logic [11:0] core_csr_addr;
    logic [2:0]  core_csr_func;
    logic [31:0] core_csr_wdata, core_csr_rdata;
    logic        core_stall;
    logic        host_req_valid, host_req_ready, host_req_we;
    logic [11:0] host_req_addr;
    logic [31:0] host_req_wdata;
    logic        host_rsp_valid, host_rsp_ready;
    logic [31:0] host_rsp_data;
    logic        csr_we, csr_rd;
    logic [11:0] csr_addr;
    logic [2:0]  csr_func;
    logic [31:0] csr_data_in, csr_data_out;
`ifdef CSR_ARB_PERF_EN
    logic [31:0] arb_stall_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    csr_arbiter #(.DWIDTH(32), .MAX_WAIT(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_csr_we    (core_csr_we),
        .core_csr_rd    (core_csr_rd),
        .core_csr_addr  (core_csr_addr),
        .core_csr_func  (core_csr_func),
        .core_csr_wdata (core_csr_wdata),
        .core_csr_rdata (core_csr_rdata),
        .core_stall     (core_stall),
        .host_req_valid (host_req_valid),
        .host_req_ready (host_req_ready),
        .host_req_we    (host_req_we),
        .host_req_addr  (host_req_addr),
        .host_req_wdata (host_req_wdata),
        .host_rsp_valid (host_rsp_valid),
        .host_rsp_data  (host_rsp_data),
        .host_rsp_ready (host_rsp_ready),
        .csr_we         (csr_we),
        .csr_rd         (csr_rd),
        .csr_addr       (csr_addr),
        .csr_func       (csr_func),
        .csr_data_in    (csr_data_in),
        .csr_data_out   (csr_data_out)
`ifdef CSR_ARB_PERF_EN
        ,
        .arb_stall_cnt  (arb_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic cwe, input logic crd, input logic [11:0] caddr,
                                 input logic [31:0] cwdata, input logic hvalid, input logic hwe,
                                 input logic [11:0] haddr, input logic [31:0] hwdata,
                                 input logic rready, input logic [31:0] csr_out);
        core_csr_we    = cwe;
        core_csr_rd    = crd;
        core_csr_addr  = caddr;
        core_csr_func  = 3'b010;
        core_csr_wdata = cwdata;
        host_req_valid = hvalid;
        host_req_we    = hwe;
        host_req_addr  = haddr;
        host_req_wdata = hwdata;
        host_rsp_ready = rready;
        csr_data_out   = csr_out;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        applyStimulus(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_rsp_valid", 32'(host_rsp_valid), 32'h0);
        checkOutput("rst_rsp_data", host_rsp_data, 32'h0);
        checkOutput("rst_req_ready", 32'(host_req_ready), 32'h0);
        checkOutput("rst_csr_we", 32'(csr_we), 32'h0);
        checkOutput("rst_csr_rd", 32'(csr_rd), 32'h0);
        checkOutput("rst_csr_addr", 32'(csr_addr), 32'h0);
        @(negedge clk) rst_n = 1'b1;

        $display("[TB] core-only accesses");
        applyStimulus(1, 0, 12'h51E, 32'hDEADBEEF, 0, 0, 12'h0, 32'h0, 0, 32'h0);
        #1;
        checkOutput("core_wr_we", 32'(csr_we), 32'h1);
        checkOutput("core_wr_rd", 32'(csr_rd), 32'h0);
        checkOutput("core_wr_addr", 32'(csr_addr), 32'h51E);
        checkOutput("core_wr_func", 32'(csr_func), 32'h2);
        checkOutput("core_wr_data", csr_data_in, 32'hDEADBEEF);
        checkOutput("core_wr_stall", 32'(core_stall), 32'h0);
        @(negedge clk);
        applyStimulus(0, 1, 12'h300, 32'h0, 0, 0, 12'h0, 32'h0, 0, 32'hCAFEF00D);
        #1;
        checkOutput("core_rd_rdata", core_csr_rdata, 32'hCAFEF00D);
        checkOutput("core_rd_rd", 32'(csr_rd), 32'h1);
        checkOutput("core_rd_we", 32'(csr_we), 32'h0);
        checkOutput("core_rd_addr", 32'(csr_addr), 32'h300);
        @(negedge clk);
        applyStimulus(0, 0, 12'h300, 32'h5, 0, 0, 12'h0, 32'h0, 0, 32'h0);
        #1;
        checkOutput("idle_rd", 32'(csr_rd), 32'h0);
        checkOutput("idle_addr", 32'(csr_addr), 32'h0);
        checkOutput("idle_data", csr_data_in, 32'h0);

        $display("[TB] host-only read with response backpressure");
        @(negedge clk);
        applyStimulus(0, 0, 12'h0, 32'h0, 1, 0, 12'h51E, 32'h0, 0, 32'h12345678);
        #1;
        checkOutput("hrd_ready", 32'(host_req_ready), 32'h1);
        checkOutput("hrd_csr_rd", 32'(csr_rd), 32'h1);
        checkOutput("hrd_csr_we", 32'(csr_we), 32'h0);
        checkOutput("hrd_csr_addr", 32'(csr_addr), 32'h51E);
        checkOutput("hrd_csr_func", 32'(csr_func), 32'h1);
        checkOutput("hrd_stall", 32'(core_stall), 32'h0);
        @(negedge clk);
        applyStimulus(1, 0, 12'h340, 32'h55, 1, 1, 12'h7C0, 32'h11112222, 0, 32'h99999999);
        #1;
        checkOutput("hrd_rsp_valid", 32'(host_rsp_valid), 32'h1);
        checkOutput("hrd_rsp_data", host_rsp_data, 32'h12345678);
        checkOutput("rsp_req_ready", 32'(host_req_ready), 32'h0);
        checkOutput("rsp_core_we", 32'(csr_we), 32'h1);
        checkOutput("rsp_core_addr", 32'(csr_addr), 32'h340);
        checkOutput("rsp_core_stall", 32'(core_stall), 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            applyStimulus(1, 1, 12'h341, 32'h0, 1, 1, 12'h7C0, 32'h11112222, 0, 32'(i));
            #1;
            checkOutput("bp_rsp_valid", 32'(host_rsp_valid), 32'h1);
            checkOutput("bp_rsp_data", host_rsp_data, 32'h12345678);
            checkOutput("bp_req_ready", 32'(host_req_ready), 32'h0);
            checkOutput("bp_stall", 32'(core_stall), 32'h0);
            checkOutput("bp_core_rdata", core_csr_rdata, 32'(i));
        end
        @(negedge clk);
        applyStimulus(0, 0, 12'h0, 32'h0, 1, 1, 12'h7C0, 32'h11112222, 1, 32'h0);
        #1;
        checkOutput("hs_rsp_valid", 32'(host_rsp_valid), 32'h1);
        checkOutput("hs_req_ready", 32'(host_req_ready), 32'h0);

        $display("[TB] host write returns old value");
        @(negedge clk);
        applyStimulus(0, 0, 12'h0, 32'h0, 1, 1, 12'h7C0, 32'h11112222, 0, 32'hAAAA5555);
        #1;
        checkOutput("hwr_rsp_valid", 32'(host_rsp_valid), 32'h0);
        checkOutput("hwr_ready", 32'(host_req_ready), 32'h1);
        checkOutput("hwr_csr_we", 32'(csr_we), 32'h1);
        checkOutput("hwr_csr_rd", 32'(csr_rd), 32'h1);
        checkOutput("hwr_csr_addr", 32'(csr_addr), 32'h7C0);
        checkOutput("hwr_csr_data", csr_data_in, 32'h11112222);
        @(negedge clk);
        applyStimulus(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 1, 32'h11112222);
        #1;
        checkOutput("hwr_rsp_valid1", 32'(host_rsp_valid), 32'h1);
        checkOutput("hwr_rsp_data", host_rsp_data, 32'hAAAA5555);
        @(negedge clk);
        applyStimulus(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 0, 32'h0);
        #1;
        checkOutput("hwr_rsp_done", 32'(host_rsp_valid), 32'h0);

        $display("[TB] contention, three forced host wins");
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                applyStimulus(0, 1, 12'h300, 32'h0, 1, 0, 12'h123, 32'h0, 0, 32'h0BADF00D);
                #1;
                checkOutput("cont_blk_ready", 32'(host_req_ready), 32'h0);
                checkOutput("cont_blk_stall", 32'(core_stall), 32'h0);
                checkOutput("cont_blk_rdata", core_csr_rdata, 32'h0BADF00D);
            end
            @(negedge clk);
            #1;
            checkOutput("cont_win_ready", 32'(host_req_ready), 32'h1);
            checkOutput("cont_win_stall", 32'(core_stall), 32'h1);
            checkOutput("cont_win_rdata", core_csr_rdata, 32'h0);
            checkOutput("cont_win_addr", 32'(csr_addr), 32'h123);
            checkOutput("cont_win_func", 32'(csr_func), 32'h1);
            @(negedge clk);
            applyStimulus(0, 1, 12'h300, 32'h0, 0, 0, 12'h0, 32'h0, 1, 32'h0BADF00D);
            #1;
            checkOutput("cont_after_stall", 32'(core_stall), 32'h0);
            checkOutput("cont_rsp_valid", 32'(host_rsp_valid), 32'h1);
            checkOutput("cont_rsp_data", host_rsp_data, 32'h0BADF00D);
            checkOutput("cont_core_addr", 32'(csr_addr), 32'h300);
        end
        @(negedge clk);
        applyStimulus(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 0, 32'h0);
        #1;
`ifdef CSR_ARB_PERF_EN
        checkOutput("perf_stall_cnt", arb_stall_cnt, 32'h3);
`endif

        $display("[TB] wait counter clears when host drops valid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(0, 1, 12'h300, 32'h0, 1, 0, 12'h124, 32'h0, 0, 32'h0);
            #1;
            checkOutput("clr_pre_ready", 32'(host_req_ready), 32'h0);
        end
        @(negedge clk);
        applyStimulus(0, 1, 12'h300, 32'h0, 0, 0, 12'h124, 32'h0, 0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus(0, 1, 12'h300, 32'h0, 1, 0, 12'h124, 32'h0, 0, 32'h0);
            #1;
            checkOutput("clr_blk_ready", 32'(host_req_ready), 32'h0);
        end
        @(negedge clk);
        #1;
        checkOutput("clr_win_ready", 32'(host_req_ready), 32'h1);
        @(negedge clk);
        applyStimulus(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 1, 32'h0);

        $display("[TB] reset during pending response");
        @(negedge clk);
        applyStimulus(0, 0, 12'h0, 32'h0, 1, 0, 12'h305, 32'h0, 0, 32'h00000077);
        #1;
        checkOutput("rr_ready", 32'(host_req_ready), 32'h1);
        @(negedge clk);
        applyStimulus(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 0, 32'h0);
        #1;
        checkOutput("rr_rsp_valid", 32'(host_rsp_valid), 32'h1);
        checkOutput("rr_rsp_data", host_rsp_data, 32'h00000077);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rr_async_valid", 32'(host_rsp_valid), 32'h0);
        checkOutput("rr_async_data", host_rsp_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 12'h0, 32'h0, 1, 0, 12'h306, 32'h0, 0, 32'h0);
        #1;
        checkOutput("rr_idle_ready", 32'(host_req_ready), 32'h1);
        checkOutput("rr_idle_addr", 32'(csr_addr), 32'h306);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/csr_arbiter.md
Name: csr_arbiter

Overview:
- Arbitrates the single CSR file port in the execute stage between two requesters.
- Requester 1 is the core pipeline: single-cycle, has priority.
- Requester 2 is a host/debug port using a valid/ready request and a valid/ready response.
- A saturating starvation counter guarantees host progress by stalling the core for one cycle when the host has waited too long.

Parameters:
- DWIDTH, 32, CSR data width.
- MAX_WAIT, 8, cycles a host request may be blocked before it wins over the core (1..255).

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- core_csr_we  input  1  core CSR write request
- core_csr_rd  input  1  core CSR read request
- core_csr_addr  input  12  core CSR address
- core_csr_func  input  3  core CSR funct3 (FNC_CSRRW / FNC_CSRRWI ...)
- core_csr_wdata  input  DWIDTH  core write data (rs1 or zimm already selected)
- core_csr_rdata  output  DWIDTH  CSR read data to core
- core_stall  output  1  core access not performed this cycle; pipeline must hold
- host_req_valid  input  1  host request valid
- host_req_ready  output  1  host request accepted this cycle
- host_req_we  input  1  1 = write, 0 = read
- host_req_addr  input  12  host CSR address
- host_req_wdata  input  DWIDTH  host write data
- host_rsp_valid  output  1  host response valid
- host_rsp_data  output  DWIDTH  old CSR value returned to host
- host_rsp_ready  input  1  host consumes response
- csr_we  output  1  to CSR file
- csr_rd  output  1  to CSR file
- csr_addr  output  12  to CSR file
- csr_func  output  3  to CSR file
- csr_data_in  output  DWIDTH  to CSR file
- csr_data_out  input  DWIDTH  from CSR file (combinational read)

Behaviour:
- core_act = core_csr_we | core_csr_rd.
- States: IDLE, RSP. Reset: state IDLE, host_rsp_valid 0, host_rsp_data 0, wait_cnt 0.
- IDLE, host_win = host_req_valid & (~core_act | wait_cnt == MAX_WAIT).
  - host_req_ready = host_win, combinational.
  - On host_win, CSR port is driven by the host:
    - csr_we = host_req_we, csr_rd = 1, csr_addr = host_req_addr, csr_func = FNC_CSRRW, csr_data_in = host_req_wdata.
    - csr_data_out is captured into host_rsp_data; next state RSP.
  - On host_win with core_act: core_stall = 1, core_csr_rdata = 0, core access suppressed.
  - Otherwise the CSR port passes core signals straight through; core_csr_rdata = csr_data_out; core_stall = 0.
- RSP:
  - host_rsp_valid = 1; host_req_ready = 0; core owns the port unconditionally; core_stall = 0.
  - host_rsp_valid & host_rsp_ready moves state to IDLE at the next edge.
  - A new host request may be accepted no earlier than the cycle after the response handshake.
- When no requester is active: csr_we = 0, csr_rd = 0; addr/func/data don't-care (drive 0).
- wait_cnt:
  - In IDLE, increments when host_req_valid & core_act & ~host_win; saturates at MAX_WAIT.
  - Clears on host acceptance or when host_req_valid = 0.
  - Holds in RSP.
- Core is never stalled two consecutive cycles by the arbiter; latency is 0 cycles for the core when not stalled.
- Host latency: accept to host_rsp_valid = 1 cycle.
- Host write returns the pre-write value (CSRRW semantics).
- Reset asserted mid-RSP: the pending response is dropped and host_rsp_valid falls immediately (asynchronous reset).
- host_req_valid must stay high with stable fields until host_req_ready; the arbiter need not check this.

Optional Feature:
- Macro: CSR_ARB_PERF_EN.
- Defined:
  - Adds output arb_stall_cnt [31:0], reset 0.
  - Increments every cycle core_stall = 1; saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Core-only: core_csr_we=1, addr 0x51E, wdata 0xDEADBEEF -> csr_we=1, addr 0x51E, csr_data_in 0xDEADBEEF same cycle, core_stall=0.
- Host-only read: host_req_valid=1, we=0, addr 0x51E with CSR holding 0x12345678 -> ready=1 same cycle; next cycle host_rsp_valid=1, data 0x12345678; held until rsp_ready.
- Contention: core_act held high, host_req_valid high, MAX_WAIT=8 -> host blocked 8 cycles; 9th cycle host_req_ready=1, core_stall=1; next cycle core_stall=0.
- Response backpressure: host_rsp_ready=0 for 5 cycles -> rsp_valid/data stable, host_req_ready=0, core accesses proceed unstalled.
- Reset during RSP: rst_n low -> host_rsp_valid 0 immediately, wait_cnt 0, state IDLE after release.
- CSR_ARB_PERF_EN: 3 forced host wins under core contention -> arb_stall_cnt = 3.
